sync_event_capture: RTL and testbench



---
 rtl/sync_event_capture_pkg.sv | 16 +
 rtl/sync_event_capture_counter.sv | 48 ++++
 rtl/sync_event_capture.sv | 112 +++++++++++
 tb/tb_sync_event_capture.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_event_capture_pkg.sv
// Shared types and helpers for the synchronized event capture block.
// Holds the detector state encoding and the high-timer width calculation.
package sync_event_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_STUCK = 2'd2
    } state_t;

    // Wide enough to hold MAX_HIGH itself, so the timer can saturate there.
    function automatic int timer_width(input int max_high);
        return $clog2(max_high + 1);
    endfunction

endpackage

// File: rtl/sync_event_capture_counter.sv
// Saturating up/down counter with a one-cycle strobe when an increment is lost.
// Simultaneous increment and decrement cancel, even at the top of the range.
module sat_updown_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_ovf
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] r_count;
    logic [W-1:0] w_count_next;
    logic         w_ovf;

    always_comb begin
        w_count_next = r_count;
        w_ovf        = 1'b0;
        if (i_inc && !i_dec) begin
            if (r_count == CNT_MAX) begin
                w_ovf = 1'b1;
            end else begin
                w_count_next = r_count + 1'b1;
            end
        end else if (i_dec && !i_inc) begin
            // An empty counter ignores decrements rather than wrapping.
            if (r_count != '0) begin
                w_count_next = r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count = r_count;
    assign o_ovf   = w_ovf;

endmodule

// File: rtl/sync_event_capture.sv
// Turns rising edges of an already-synchronized level into queued events,
// with sticky flags for dropped events and for a level held high too long.
module sync_event_capture
    import sync_event_capture_pkg::*;
#(
    parameter int CNT_W    = 4,
    parameter int MAX_HIGH = 16
) (
    input  logic             clkB,
    input  logic             rstB,
    input  logic             sync_in,
    input  logic             evt_ready,
    input  logic             clr_err,
    output logic             evt_pulse,
    output logic             evt_valid,
    output logic [CNT_W-1:0] pend_count,
    output logic             overflow,
    output logic             stuck_err
);

    localparam int                TMR_W   = timer_width(MAX_HIGH);
    localparam logic [TMR_W-1:0]  TMR_MAX = TMR_W'(MAX_HIGH);

    state_t           r_state;
    state_t           w_state_next;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_next;
    logic             r_prev;
    logic             r_pulse;
    logic             r_overflow;
    logic             r_stuck;

    logic             w_edge;
    logic             w_pop;
    logic             w_valid;
    logic             w_ovf;
    logic             w_stuck_set;
    logic [CNT_W-1:0] w_count;

    // Edges are only recognised from IDLE, so a stuck level cannot re-trigger.
    assign w_edge      = sync_in & ~r_prev & (r_state == ST_IDLE);
    assign w_valid     = (w_count != '0);
    assign w_pop       = w_valid & evt_ready;
    assign w_stuck_set = (r_state == ST_HIGH) & sync_in & (r_timer == TMR_MAX);

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    w_state_next = ST_HIGH;
                    w_timer_next = TMR_W'(1);
                end
            end
            ST_HIGH: begin
                if (!sync_in) begin
                    w_state_next = ST_IDLE;
                end else if (r_timer == TMR_MAX) begin
                    w_state_next = ST_STUCK;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            ST_STUCK: begin
                if (!sync_in) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    sat_updown_counter #(
        .W (CNT_W)
    ) u_pend_cnt (
        .clk     (clkB),
        .srst    (rstB),
        .i_inc   (w_edge),
        .i_dec   (w_pop),
        .o_count (w_count),
        .o_ovf   (w_ovf)
    );

    always_ff @(posedge clkB) begin
        if (rstB) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_prev     <= 1'b1;
            r_pulse    <= 1'b0;
            r_overflow <= 1'b0;
            r_stuck    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_timer    <= w_timer_next;
            r_prev     <= sync_in;
            r_pulse    <= w_edge;
            // A new set on the clearing clock keeps the flag high.
            r_overflow <= w_ovf | (r_overflow & ~clr_err);
            r_stuck    <= w_stuck_set | (r_stuck & ~clr_err);
        end
    end

    assign evt_pulse  = r_pulse;
    assign evt_valid  = w_valid;
    assign pend_count = w_count;
    assign overflow   = r_overflow;
    assign stuck_err  = r_stuck;

endmodule

// File: tb/tb_sync_event_capture.sv
// Directed bench for sync_event_capture with hand-computed expectations.
module tb_sync_event_capture;

    logic       clkB = 1'b0;
    logic       rstB;
    logic       sync_in;
    logic       evt_ready;
    logic       clr_err;
    logic       evt_pulse;
    logic       evt_valid;
    logic [3:0] pend_count;
    logic       overflow;
    logic       stuck_err;

    int total = 0;
    int bad   = 0;

    always #5 clkB = ~clkB;

    sync_event_capture #(
        .CNT_W    (4),
        .MAX_HIGH (16)
    ) dut (
        .clkB       (clkB),
        .rstB       (rstB),
        .sync_in    (sync_in),
        .evt_ready  (evt_ready),
        .clr_err    (clr_err),
        .evt_pulse  (evt_pulse),
        .evt_valid  (evt_valid),
        .pend_count (pend_count),
        .overflow   (overflow),
        .stuck_err  (stuck_err)
    );

    task automatic tick();
        @(posedge clkB);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        $display("check %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        rstB      = 1'b1;
        sync_in   = 1'b1;
        evt_ready = 1'b0;
        clr_err   = 1'b0;
        tick();
        tick();
        chk1("rst_pulse", evt_pulse, 1'b0);
        chk1("rst_valid", evt_valid, 1'b0);
        chk4("rst_count", pend_count, 4'd0);
        chk1("rst_ovf", overflow, 1'b0);
        chk1("rst_stuck", stuck_err, 1'b0);

        // Level already high out of reset must not count as an event.
        rstB = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("hi_out_of_rst_pulse", evt_pulse, 1'b0);
        end
        sync_in = 1'b0;
        tick();
        chk4("hi_out_of_rst_count", pend_count, 4'd0);
        chk1("hi_out_of_rst_stuck", stuck_err, 1'b0);

        // Single event, then consume it.
        sync_in = 1'b1;
        tick();
        chk1("single_pulse", evt_pulse, 1'b1);
        chk4("single_count", pend_count, 4'd1);
        chk1("single_valid", evt_valid, 1'b1);
        tick();
        chk1("single_pulse_off", evt_pulse, 1'b0);
        tick();
        sync_in = 1'b0;
        tick();
        chk4("single_hold", pend_count, 4'd1);
        evt_ready = 1'b1;
        tick();
        chk4("single_pop", pend_count, 4'd0);
        chk1("single_valid_off", evt_valid, 1'b0);
        tick();
        chk4("pop_empty_ignored", pend_count, 4'd0);
        evt_ready = 1'b0;

        // Fill to saturation, then one more rise overflows.
        for (int i = 1; i <= 15; i++) begin
            sync_in = 1'b1;
            tick();
            chk4("fill_count", pend_count, 4'(i));
            tick();
            sync_in = 1'b0;
            tick();
            tick();
        end
        chk1("fill_no_ovf", overflow, 1'b0);
        sync_in = 1'b1;
        tick();
        chk4("sat_count", pend_count, 4'd15);
        chk1("sat_ovf", overflow, 1'b1);
        tick();
        sync_in = 1'b0;
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk1("clr_ovf", overflow, 1'b0);
        chk4("clr_keeps_count", pend_count, 4'd15);

        // Rise at max with a pop on the same clock: no overflow.
        tick();
        sync_in   = 1'b1;
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk1("max_pop_pulse", evt_pulse, 1'b1);
        chk4("max_pop_count", pend_count, 4'd15);
        chk1("max_pop_no_ovf", overflow, 1'b0);
        tick();
        sync_in = 1'b0;
        tick();
        tick();

        // Overflow set on the same clock as clr_err wins.
        sync_in = 1'b1;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk1("set_beats_clr", overflow, 1'b1);
        tick();
        sync_in = 1'b0;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk1("clr_again", overflow, 1'b0);

        // Drain all pending events.
        evt_ready = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        evt_ready = 1'b0;
        chk4("drained", pend_count, 4'd0);
        chk1("drained_valid", evt_valid, 1'b0);

        // Stuck high for 20 cycles: one event, stuck after more than 16 highs.
        sync_in = 1'b1;
        tick();
        chk4("stuck_first_evt", pend_count, 4'd1);
        for (int i = 0; i < 15; i++) tick();
        chk1("stuck_not_yet", stuck_err, 1'b0);
        tick();
        chk1("stuck_set", stuck_err, 1'b1);
        tick();
        tick();
        tick();
        chk4("stuck_one_evt", pend_count, 4'd1);
        chk1("stuck_no_pulse", evt_pulse, 1'b0);
        sync_in = 1'b0;
        tick();
        chk1("stuck_sticky", stuck_err, 1'b1);
        sync_in = 1'b1;
        tick();
        chk1("after_stuck_pulse", evt_pulse, 1'b1);
        chk4("after_stuck_count", pend_count, 4'd2);
        sync_in = 1'b0;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk1("stuck_clr", stuck_err, 1'b0);
        chk4("stuck_clr_count", pend_count, 4'd2);

        // Reset in the middle of a high pulse with three events pending.
        sync_in = 1'b1;
        tick();
        chk4("pre_rst_count", pend_count, 4'd3);
        rstB = 1'b1;
        tick();
        rstB = 1'b0;
        chk4("midrst_count", pend_count, 4'd0);
        chk1("midrst_valid", evt_valid, 1'b0);
        chk1("midrst_pulse", evt_pulse, 1'b0);
        chk1("midrst_ovf", overflow, 1'b0);
        chk1("midrst_stuck", stuck_err, 1'b0);
        tick();
        chk1("midrst_high_no_evt", evt_pulse, 1'b0);
        sync_in = 1'b0;
        tick();
        sync_in = 1'b1;
        tick();
        chk1("midrst_idle_pulse", evt_pulse, 1'b1);
        chk4("midrst_idle_count", pend_count, 4'd1);
        sync_in = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
